// File: rtl/writeback_sequencer_pkg.sv
// rtl/writeback_sequencer_pkg.sv - shared writeback source selects and FSM state encoding
package writeback_sequencer_pkg;

    localparam logic [1:0] MD_F    = 2'b00;
    localparam logic [1:0] MD_MEM  = 2'b01;
    localparam logic [1:0] MD_SLT  = 2'b10;
    localparam logic [1:0] MD_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_WRITE    = 2'b10
    } wb_state_e;

endpackage

// File: rtl/writeback_sequencer_timeout_cnt.sv
// rtl/writeback_sequencer_timeout_cnt.sv - clear/enable cycle counter flagging MEM_TIMEOUT-1
module wb_timeout_cnt #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CW          = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/writeback_sequencer.sv
// rtl/writeback_sequencer.sv - sequences MUX_D select and register-file write, waiting on memory reads
module writeback_sequencer
    import writeback_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [1:0]        wb_md,
    input  logic [ADDR_W-1:0] wb_da,
    input  logic              wb_rw,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [1:0]        md_sel,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_da,
    output logic              stall,
    output logic              err_timeout,
    output logic              err_illegal
);

    wb_state_e state, next_state;
    logic      accept;
    logic      tc;
    logic      mem_req_d, rf_we_d, err_timeout_d, err_illegal_d;

    assign wb_ready = (state == ST_IDLE);
    assign stall    = ~wb_ready;
    assign accept   = wb_valid & wb_ready;

    wb_timeout_cnt #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (reset),
        .clear  (accept),
        .enable ((state == ST_MEM_WAIT) & ~mem_ack),
        .tc     (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Illegal selects and no-write requests are consumed in IDLE without leaving it.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept && wb_rw && (wb_md != MD_RSVD)) begin
                    next_state = (wb_md == MD_MEM) ? ST_MEM_WAIT : ST_WRITE;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    next_state = ST_WRITE;
                end else if (tc) begin
                    next_state = ST_IDLE;
                end
            end
            ST_WRITE: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered, so they align with it.
    always_comb begin
        mem_req_d     = (next_state == ST_MEM_WAIT);
        rf_we_d       = (next_state == ST_WRITE);
        err_timeout_d = (state == ST_MEM_WAIT) & ~mem_ack & tc;
        err_illegal_d = accept & (wb_md == MD_RSVD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req     <= 1'b0;
            rf_we       <= 1'b0;
            err_timeout <= 1'b0;
            err_illegal <= 1'b0;
            md_sel      <= MD_F;
            rf_da       <= '0;
        end else begin
            mem_req     <= mem_req_d;
            rf_we       <= rf_we_d;
            err_timeout <= err_timeout_d;
            err_illegal <= err_illegal_d;
            if (accept) begin
                md_sel <= wb_md;
                rf_da  <= wb_da;
            end
        end
    end

endmodule

// File: tb/tb_writeback_sequencer.sv
// tb/tb_writeback_sequencer.sv - randomized self-checking bench for writeback_sequencer
module tb_writeback_sequencer;

    localparam int AW = 5;
    localparam int MT = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_valid;
    logic          wb_ready;
    logic [1:0]    wb_md;
    logic [AW-1:0] wb_da;
    logic          wb_rw;
    logic          mem_req;
    logic          mem_ack;
    logic [1:0]    md_sel;
    logic          rf_we;
    logic [AW-1:0] rf_da;
    logic          stall;
    logic          err_timeout;
    logic          err_illegal;

    int n_cmp = 0;
    int n_err = 0;

    writeback_sequencer #(.ADDR_W(AW), .MEM_TIMEOUT(MT)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_md       (wb_md),
        .wb_da       (wb_da),
        .wb_rw       (wb_rw),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .md_sel      (md_sel),
        .rf_we       (rf_we),
        .rf_da       (rf_da),
        .stall       (stall),
        .err_timeout (err_timeout),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(wb_ready), 1);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_memreq"}, 32'(mem_req), 0);
        chk({tag, "_rfwe"}, 32'(rf_we), 0);
    endtask

    // One request issued from IDLE; expected behaviour comes straight from the writeback rules.
    // ack_after = cycle of mem_req on which mem_ack is raised (0 or > MT: never).
    task automatic txn(input logic [1:0] md, input logic [AW-1:0] da, input logic rw, input int ack_after);
        chk("pre_ready", 32'(wb_ready), 1);
        wb_valid = 1'b1; wb_md = md; wb_da = da; wb_rw = rw;
        mem_ack  = 1'($urandom_range(0, 1));
        @(negedge clk);
        wb_valid = 1'b0; wb_md = 2'($urandom); wb_da = AW'($urandom); wb_rw = 1'($urandom);
        mem_ack  = 1'b0;
        chk("acc_mdsel", 32'(md_sel), 32'(md));
        chk("acc_rfda", 32'(rf_da), 32'(da));
        if (md == 2'b11) begin
            chk("ill_pulse", 32'(err_illegal), 1);
            chk_idle("ill");
            @(negedge clk);
            chk("ill_clear", 32'(err_illegal), 0);
            chk_idle("ill2");
        end else if (!rw) begin
            chk("norw_errs", 32'({err_illegal, err_timeout}), 0);
            chk_idle("norw");
        end else if (md != 2'b01) begin
            chk("wr_rfwe", 32'(rf_we), 1);
            chk("wr_ready", 32'(wb_ready), 0);
            chk("wr_stall", 32'(stall), 1);
            chk("wr_memreq", 32'(mem_req), 0);
            wb_valid = 1'b1;
            @(negedge clk);
            wb_valid = 1'b0;
            chk_idle("wr_after");
            chk("wr_hold_mdsel", 32'(md_sel), 32'(md));
            chk("wr_hold_rfda", 32'(rf_da), 32'(da));
        end else begin
            for (int k = 1; k <= MT; k++) begin
                chk("mw_memreq", 32'(mem_req), 1);
                chk("mw_rfwe", 32'(rf_we), 0);
                chk("mw_ready", 32'(wb_ready), 0);
                chk("mw_errto", 32'(err_timeout), 0);
                wb_valid = 1'($urandom);
                mem_ack  = (k == ack_after);
                @(negedge clk);
                wb_valid = 1'b0;
                if (k == ack_after) begin
                    mem_ack = 1'b0;
                    chk("ack_rfwe", 32'(rf_we), 1);
                    chk("ack_memreq", 32'(mem_req), 0);
                    chk("ack_mdsel", 32'(md_sel), 1);
                    chk("ack_rfda", 32'(rf_da), 32'(da));
                    @(negedge clk);
                    chk_idle("ack_after");
                    break;
                end else if (k == MT) begin
                    chk("to_pulse", 32'(err_timeout), 1);
                    chk_idle("to");
                    @(negedge clk);
                    chk("to_clear", 32'(err_timeout), 0);
                    chk_idle("to2");
                end
            end
        end
    endtask

    initial begin
        bit            busy;
        logic [1:0]    cur_md;
        logic [AW-1:0] cur_da;
        int            r;

        reset = 1'b1; wb_valid = 1'b0; wb_md = 2'b00; wb_da = '0; wb_rw = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("rst");
        chk("rst_mdsel", 32'(md_sel), 0);
        chk("rst_rfda", 32'(rf_da), 0);
        chk("rst_errs", 32'({err_illegal, err_timeout}), 0);
        reset = 1'b0;
        @(negedge clk);

        txn(2'b00, 5'd7, 1'b1, 0);
        txn(2'b01, 5'd3, 1'b1, 4);
        txn(2'b01, 5'd5, 1'b1, 0);
        txn(2'b01, 5'd9, 1'b1, MT);
        txn(2'b11, 5'd9, 1'b1, 0);
        txn(2'b01, 5'd4, 1'b0, 0);
        txn(2'b10, 5'd31, 1'b1, 0);

        // Held request alternating SLT/F: a write lands every second cycle.
        busy = 1'b0; cur_md = 2'b10; cur_da = AW'($urandom);
        wb_valid = 1'b1; wb_md = cur_md; wb_da = cur_da; wb_rw = 1'b1;
        for (int c = 0; c < 12; c++) begin
            mem_ack = 1'($urandom);
            @(negedge clk);
            if (!busy) begin
                chk("b2b_rfwe", 32'(rf_we), 1);
                chk("b2b_mdsel", 32'(md_sel), 32'(cur_md));
                chk("b2b_rfda", 32'(rf_da), 32'(cur_da));
                chk("b2b_memreq", 32'(mem_req), 0);
                busy = 1'b1;
                cur_md = cur_md ^ 2'b10; cur_da = AW'($urandom);
                wb_md = cur_md; wb_da = cur_da;
            end else begin
                chk_idle("b2b_gap");
                busy = 1'b0;
            end
        end
        wb_valid = 1'b0; mem_ack = 1'b0;

        // Reset while waiting on memory must abort without a write.
        wb_valid = 1'b1; wb_md = 2'b01; wb_da = 5'd6; wb_rw = 1'b1;
        @(negedge clk);
        wb_valid = 1'b0;
        chk("rmw_memreq", 32'(mem_req), 1);
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b1;
        #1;
        chk_idle("rmw_rst");
        chk("rmw_rfda", 32'(rf_da), 0);
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_idle("rmw_after");
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0]    md;
            logic [AW-1:0] da;
            logic          rw;
            int            aa;
            md = 2'($urandom_range(0, 3));
            da = AW'($urandom);
            rw = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 5);
            aa = (r == 0) ? 0 : $urandom_range(1, MT + 1);
            if ($urandom_range(0, 1) == 1) begin
                mem_ack = 1'($urandom);
                @(negedge clk);
                mem_ack = 1'b0;
                chk_idle("rnd_gap");
            end
            txn(md, da, rw, aa);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
